// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the arbiter and the unified memory.
// The arbiter uses the slave view; requesters and the memory model use the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 30
);
    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_rsp_valid;
    logic [31:0]       if_rsp_data;

    logic              ls_req_valid;
    logic              ls_req_ready;
    logic [ADDR_W-1:0] ls_addr;
    logic              ls_we;
    logic [3:0]        ls_wstrb;
    logic [31:0]       ls_wdata;
    logic              ls_rsp_valid;
    logic [31:0]       ls_rsp_data;

    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  if_req_valid, if_addr, if_flush,
        input  ls_req_valid, ls_addr, ls_we, ls_wstrb, ls_wdata,
        input  mem_rdata,
        output if_req_ready, if_rsp_valid, if_rsp_data,
        output ls_req_ready, ls_rsp_valid, ls_rsp_data,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req_valid, if_addr, if_flush,
        output ls_req_valid, ls_addr, ls_we, ls_wstrb, ls_wdata,
        output mem_rdata,
        input  if_req_ready, if_rsp_valid, if_rsp_data,
        input  ls_req_ready, ls_rsp_valid, ls_rsp_data,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: load/store has priority, a starvation counter forces fetch
// progress, and read responses return one cycle after issue tagged to their requester.
module mem_port_arbiter #(
    parameter int ADDR_W       = 30,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    mem_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PEND_IF = 2'd1,
        ST_PEND_LS = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  starve_cnt_r;
    logic [3:0]  starve_cnt_s;
    logic        flush_pending_r;
    logic        flush_pending_s;
    logic        store_r;
    logic        store_s;
    logic        force_if_s;
    logic        ls_grant_s;
    logic        if_grant_s;

    // Issue-cycle grant and memory command, driven straight from the winning request.
    always_comb begin
        force_if_s    = (starve_cnt_r >= LIMIT) && bus.if_req_valid;
        ls_grant_s    = bus.ls_req_valid && !force_if_s;
        if_grant_s    = bus.if_req_valid && !ls_grant_s;
        bus.ls_req_ready = ls_grant_s;
        bus.if_req_ready = if_grant_s;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 4'b0000;
        bus.mem_addr  = '0;
        bus.mem_wdata = 32'h0000_0000;
        if (ls_grant_s) begin
            bus.mem_en    = 1'b1;
            bus.mem_addr  = bus.ls_addr;
            bus.mem_we    = bus.ls_we ? bus.ls_wstrb : 4'b0000;
            bus.mem_wdata = bus.ls_wdata;
        end else if (if_grant_s) begin
            bus.mem_en    = 1'b1;
            bus.mem_addr  = bus.if_addr;
            bus.mem_wdata = bus.ls_wdata;
        end else begin
            bus.mem_en    = 1'b0;
        end
    end

    // Next-state for the response tag, starvation counter, flush and store flags; response outputs.
    always_comb begin
        state_s         = ST_IDLE;
        starve_cnt_s    = starve_cnt_r;
        flush_pending_s = bus.if_flush && if_grant_s;
        store_s         = ls_grant_s && bus.ls_we;
        bus.if_rsp_valid = 1'b0;
        bus.if_rsp_data  = 32'h0000_0000;
        bus.ls_rsp_valid = 1'b0;
        bus.ls_rsp_data  = 32'h0000_0000;

        if (ls_grant_s) begin
            state_s = ST_PEND_LS;
        end else if (if_grant_s) begin
            state_s = ST_PEND_IF;
        end else begin
            state_s = ST_IDLE;
        end

        // Fetch losing to load/store ages the counter; any fetch grant or idle fetch resets it.
        if (if_grant_s || !bus.if_req_valid) begin
            starve_cnt_s = 4'd0;
        end else if (ls_grant_s && starve_cnt_r != 4'd15) begin
            starve_cnt_s = starve_cnt_r + 4'd1;
        end else begin
            starve_cnt_s = starve_cnt_r;
        end

        case (state_r)
            ST_PEND_IF: begin
                bus.if_rsp_valid = !flush_pending_r && !bus.if_flush;
                bus.if_rsp_data  = bus.mem_rdata;
            end
            ST_PEND_LS: begin
                bus.ls_rsp_valid = 1'b1;
                bus.ls_rsp_data  = store_r ? 32'h0000_0000 : bus.mem_rdata;
            end
            default: begin
                bus.if_rsp_valid = 1'b0;
                bus.ls_rsp_valid = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset; a reset drops any in-flight response.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r         <= ST_IDLE;
            starve_cnt_r    <= 4'd0;
            flush_pending_r <= 1'b0;
            store_r         <= 1'b0;
        end else begin
            state_r         <= state_s;
            starve_cnt_r    <= starve_cnt_s;
            flush_pending_r <= flush_pending_s;
            store_r         <= store_s;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: each task drives one scenario and checks
// grants, memory commands and tagged responses against hand-computed values.
module tb_mem_port_arbiter;
    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    mem_port_arbiter_if #(.ADDR_W(30)) bus ();

    mem_port_arbiter #(.ADDR_W(30), .STARVE_LIMIT(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req_valid = 1'b0;
        bus.if_addr      = 30'd0;
        bus.if_flush     = 1'b0;
        bus.ls_req_valid = 1'b0;
        bus.ls_addr      = 30'd0;
        bus.ls_we        = 1'b0;
        bus.ls_wstrb     = 4'b0000;
        bus.ls_wdata     = 32'h0000_0000;
        bus.mem_rdata    = 32'h0000_0000;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        n_cmp++;
        if ({bus.if_rsp_valid, bus.ls_rsp_valid, bus.mem_en} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_valids: got %b expected 000", {bus.if_rsp_valid, bus.ls_rsp_valid, bus.mem_en});
        end
        n_cmp++;
        if ({dut.state_r, dut.starve_cnt_r, dut.flush_pending_r} !== 7'd0) begin
            n_err++;
            $display("FAIL reset_state: got state=%0d cnt=%0d flush=%b expected 0/0/0",
                     dut.state_r, dut.starve_cnt_r, dut.flush_pending_r);
        end
        n_cmp++;
        if ({bus.if_rsp_data, bus.ls_rsp_data} !== 64'd0) begin
            n_err++;
            $display("FAIL reset_data: got %h/%h expected 0/0", bus.if_rsp_data, bus.ls_rsp_data);
        end
    endtask

    task automatic test_fetch_stream();
        logic [31:0] rd [3];
        rd[0] = 32'h0000_0013;
        rd[1] = 32'h0010_0093;
        rd[2] = 32'h0020_0113;
        for (int i = 0; i < 4; i++) begin
            tick();
            idle_inputs();
            bus.if_req_valid = (i < 3);
            bus.if_addr      = (i < 3) ? 30'(i) : 30'd0;
            bus.mem_rdata    = (i > 0) ? rd[i-1] : 32'h0000_0000;
            #1;
            n_cmp++;
            if ({bus.if_req_ready, bus.mem_en, bus.mem_we, bus.mem_addr} !==
                {(i < 3), (i < 3), 4'b0000, ((i < 3) ? 30'(i) : 30'd0)}) begin
                n_err++;
                $display("FAIL fetch_issue[%0d]: got rdy=%b en=%b we=%b addr=%0d expected rdy/en=%b we=0 addr=%0d",
                         i, bus.if_req_ready, bus.mem_en, bus.mem_we, bus.mem_addr, (i < 3), (i < 3) ? i : 0);
            end
            n_cmp++;
            if ({bus.if_rsp_valid, bus.if_rsp_data} !== {(i > 0), ((i > 0) ? rd[i-1] : 32'h0000_0000)}) begin
                n_err++;
                $display("FAIL fetch_rsp[%0d]: got v=%b d=%h expected v=%b d=%h",
                         i, bus.if_rsp_valid, bus.if_rsp_data, (i > 0), (i > 0) ? rd[i-1] : 32'h0000_0000);
            end
        end
    endtask

    task automatic test_contention();
        logic [7:0] exp_if;
        logic [3:0] exp_cnt [8];
        exp_if = 8'b0001_0000;
        exp_cnt = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd2};
        for (int k = 0; k < 9; k++) begin
            tick();
            idle_inputs();
            bus.if_req_valid = (k < 8);
            bus.ls_req_valid = (k < 8);
            bus.if_addr      = 30'd5;
            bus.ls_addr      = 30'd9;
            bus.mem_rdata    = 32'hA000_0000 + 32'(k);
            #1;
            if (k < 8) begin
                n_cmp++;
                if ({bus.if_req_ready, bus.ls_req_ready, dut.starve_cnt_r, bus.mem_addr} !==
                    {exp_if[k], !exp_if[k], exp_cnt[k], (exp_if[k] ? 30'd5 : 30'd9)}) begin
                    n_err++;
                    $display("FAIL contention_grant[%0d]: got if=%b ls=%b cnt=%0d addr=%0d expected if=%b ls=%b cnt=%0d",
                             k, bus.if_req_ready, bus.ls_req_ready, dut.starve_cnt_r, bus.mem_addr,
                             exp_if[k], !exp_if[k], exp_cnt[k]);
                end
            end
            if (k > 0) begin
                n_cmp++;
                if ({bus.if_rsp_valid, bus.ls_rsp_valid, bus.ls_rsp_data} !==
                    {exp_if[k-1], !exp_if[k-1], (exp_if[k-1] ? 32'h0000_0000 : 32'hA000_0000 + 32'(k))}) begin
                    n_err++;
                    $display("FAIL contention_rsp[%0d]: got ifv=%b lsv=%b lsd=%h expected ifv=%b lsv=%b",
                             k, bus.if_rsp_valid, bus.ls_rsp_valid, bus.ls_rsp_data, exp_if[k-1], !exp_if[k-1]);
                end
            end
        end
    endtask

    task automatic test_store_load();
        tick();
        idle_inputs();
        bus.ls_req_valid = 1'b1;
        bus.ls_we        = 1'b1;
        bus.ls_addr      = 30'h40;
        bus.ls_wstrb     = 4'b0011;
        bus.ls_wdata     = 32'hDEAD_BEEF;
        #1;
        n_cmp++;
        if ({bus.ls_req_ready, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !==
            {1'b1, 1'b1, 4'b0011, 30'h40, 32'hDEAD_BEEF}) begin
            n_err++;
            $display("FAIL store_issue: got rdy=%b en=%b we=%b addr=%h wd=%h expected 1 1 0011 40 deadbeef",
                     bus.ls_req_ready, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        tick();
        idle_inputs();
        bus.ls_req_valid = 1'b1;
        bus.ls_addr      = 30'h40;
        bus.mem_rdata    = 32'hFFFF_FFFF;
        #1;
        n_cmp++;
        if ({bus.ls_rsp_valid, bus.ls_rsp_data, bus.mem_we} !== {1'b1, 32'h0000_0000, 4'b0000}) begin
            n_err++;
            $display("FAIL store_ack: got v=%b d=%h we=%b expected 1 00000000 0000",
                     bus.ls_rsp_valid, bus.ls_rsp_data, bus.mem_we);
        end
        tick();
        idle_inputs();
        bus.mem_rdata = 32'h0000_BEEF;
        #1;
        n_cmp++;
        if ({bus.ls_rsp_valid, bus.ls_rsp_data} !== {1'b1, 32'h0000_BEEF}) begin
            n_err++;
            $display("FAIL load_rsp: got v=%b d=%h expected 1 0000beef", bus.ls_rsp_valid, bus.ls_rsp_data);
        end
        tick();
        idle_inputs();
        #1;
        n_cmp++;
        if ({bus.ls_rsp_valid, bus.ls_rsp_data} !== {1'b0, 32'h0000_0000}) begin
            n_err++;
            $display("FAIL load_idle: got v=%b d=%h expected 0 0", bus.ls_rsp_valid, bus.ls_rsp_data);
        end
    endtask

    task automatic test_flush();
        tick();
        idle_inputs();
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 30'd7;
        tick();
        idle_inputs();
        bus.if_flush  = 1'b1;
        bus.mem_rdata = 32'h0000_1234;
        #1;
        n_cmp++;
        if (bus.if_rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_next: got if_rsp_valid=%b expected 0", bus.if_rsp_valid);
        end
        // A flush while a load is outstanding must leave the load response intact.
        tick();
        idle_inputs();
        bus.ls_req_valid = 1'b1;
        bus.ls_addr      = 30'd3;
        tick();
        idle_inputs();
        bus.if_flush  = 1'b1;
        bus.mem_rdata = 32'h5555_AAAA;
        #1;
        n_cmp++;
        if ({bus.ls_rsp_valid, bus.ls_rsp_data, bus.if_rsp_valid} !== {1'b1, 32'h5555_AAAA, 1'b0}) begin
            n_err++;
            $display("FAIL flush_ls: got lsv=%b lsd=%h ifv=%b expected 1 5555aaaa 0",
                     bus.ls_rsp_valid, bus.ls_rsp_data, bus.if_rsp_valid);
        end
    endtask

    task automatic test_flush_issue();
        tick();
        idle_inputs();
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 30'd8;
        bus.if_flush     = 1'b1;
        #1;
        n_cmp++;
        if (bus.if_req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_issue_grant: got %b expected 1", bus.if_req_ready);
        end
        tick();
        idle_inputs();
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 30'd9;
        bus.mem_rdata    = 32'h0000_0088;
        #1;
        n_cmp++;
        if ({bus.if_req_ready, bus.if_rsp_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL flush_issue_suppress: got rdy=%b v=%b expected 1 0", bus.if_req_ready, bus.if_rsp_valid);
        end
        tick();
        idle_inputs();
        bus.mem_rdata = 32'h0000_0099;
        #1;
        n_cmp++;
        if ({bus.if_rsp_valid, bus.if_rsp_data} !== {1'b1, 32'h0000_0099}) begin
            n_err++;
            $display("FAIL flush_issue_next: got v=%b d=%h expected 1 00000099", bus.if_rsp_valid, bus.if_rsp_data);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        idle_inputs();
        bus.if_req_valid = 1'b1;
        bus.ls_req_valid = 1'b1;
        bus.ls_addr      = 30'd11;
        tick();
        bus.mem_rdata = 32'h1111_2222;
        reset_n       = 1'b0;
        #1;
        n_cmp++;
        if ({bus.ls_req_ready, dut.starve_cnt_r} !== {1'b1, 4'd1}) begin
            n_err++;
            $display("FAIL reset_mid_pre: got rdy=%b cnt=%0d expected 1 1", bus.ls_req_ready, dut.starve_cnt_r);
        end
        tick();
        reset_n = 1'b1;
        idle_inputs();
        bus.mem_rdata = 32'h3333_4444;
        #1;
        n_cmp++;
        if ({bus.ls_rsp_valid, bus.ls_rsp_data, bus.if_rsp_valid} !== {1'b0, 32'h0000_0000, 1'b0}) begin
            n_err++;
            $display("FAIL reset_mid_rsp: got lsv=%b lsd=%h ifv=%b expected 0 0 0",
                     bus.ls_rsp_valid, bus.ls_rsp_data, bus.if_rsp_valid);
        end
        n_cmp++;
        if ({dut.state_r, dut.starve_cnt_r} !== 6'd0) begin
            n_err++;
            $display("FAIL reset_mid_state: got state=%0d cnt=%0d expected 0 0", dut.state_r, dut.starve_cnt_r);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_fetch_stream();
        test_contention();
        test_store_load();
        test_flush();
        test_flush_issue();
        test_reset_mid();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
